ct_split_fifo: RTL and testbench

Buffered multicast split node for the packet interconnect. It decodes the flow_id carried in each input beat and looks it up in a static flow table. It then pushes the beat into a per-output FIFO for every output that flow targets. The per-output FIFOs decouple outputs from one another, so a stalled output does not block the others while its FIFO has space, and there is no combinational path from i_ready to o_ready. It sits in the same places as the unbuffered split, where multicast fan-out crosses consumers with uneven backpressure.

---
 rtl/ct_split_fifo.sv | 123 ++++++++++++
 tb/tb_ct_split_fifo.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_split_fifo.sv
// ct_split_fifo: buffered multicast split node.
// Flow-table lookup forks each accepted beat into per-output FIFOs.
module ct_split_fifo #(
    parameter int unsigned            NO           = 2,
    parameter int unsigned            WO           = 32,
    parameter int unsigned            NF           = 2,
    parameter int unsigned            WF           = 4,
    parameter logic [NF*WF-1:0]       FLOWS        = '0,
    parameter logic [NF*NO-1:0]       ENABLES      = '0,
    parameter int unsigned            FLOW_LOC     = 0,
    parameter int unsigned            DEPTH        = 2,
    parameter bit                     DROP_UNKNOWN = 1'b1,
    parameter int unsigned            CW           = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [WO-1:0]   i_data,
    input  logic            i_valid,
    output logic            o_ready,
    output logic [NO*WO-1:0] o_data,
    output logic [NO-1:0]   o_valid,
    input  logic [NO-1:0]   i_ready,
    output logic [CW-1:0]   o_drop_count,
    output logic            o_unknown
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WF-1:0] fid;
    logic [NO-1:0] mask;
    logic [NO-1:0] full;
    logic          hit;
    logic          accept;
    logic          drop;
    logic [CW-1:0] drop_q, drop_d;
    logic          unk_q, unk_d;

    assign fid = i_data[FLOW_LOC +: WF];

    // Flow lookup: scan high to low so the lowest matching index wins.
    always_comb begin
        hit  = 1'b0;
        mask = '0;
        for (int k = NF - 1; k >= 0; k--) begin
            if (FLOWS[WF*k +: WF] == fid) begin
                hit  = 1'b1;
                mask = ENABLES[NO*k +: NO];
            end
        end
        if (!hit) begin
            mask = DROP_UNKNOWN ? '0 : '1;
        end
    end

    assign o_ready = &(~mask | ~full);
    assign accept  = i_valid & o_ready;
    assign drop    = accept & (mask == '0);

    for (genvar g = 0; g < NO; g++) begin : g_out
        logic [WO-1:0] mem_q [DEPTH];
        logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
        logic [AW:0]   cnt_q, cnt_d;
        logic          push, pop;

        assign full[g]    = (cnt_q == CNT_FULL);
        assign o_valid[g] = (cnt_q != '0);
        assign push       = accept & mask[g];
        assign pop        = o_valid[g] & i_ready[g];
        assign o_data[g*WO +: WO] = mem_q[rd_q];

        // Pointer and occupancy next-state; pointers wrap naturally.
        always_comb begin
            wr_d  = wr_q;
            rd_d  = rd_q;
            cnt_d = cnt_q;
            if (push) wr_d = wr_q + 1'b1;
            if (pop)  rd_d = rd_q + 1'b1;
            if (push && !pop) cnt_d = cnt_q + 1'b1;
            else if (pop && !push) cnt_d = cnt_q - 1'b1;
        end

        // FIFO control state; reset flushes buffered beats.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
            end else begin
                wr_q  <= wr_d;
                rd_q  <= rd_d;
                cnt_q <= cnt_d;
            end
        end

        // Storage is left unreset; occupancy guards every read.
        always_ff @(posedge clk) begin
            if (push) mem_q[wr_q] <= i_data;
        end
    end

    // Saturating drop counter and unknown-flow pulse.
    always_comb begin
        drop_d = drop_q;
        unk_d  = accept & ~hit;
        if (drop && (drop_q != '1)) drop_d = drop_q + 1'b1;
    end

    // Drop statistics registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_q <= '0;
            unk_q  <= 1'b0;
        end else begin
            drop_q <= drop_d;
            unk_q  <= unk_d;
        end
    end

    assign o_drop_count = drop_q;
    assign o_unknown    = unk_q;

endmodule

// File: tb/tb_ct_split_fifo.sv
// tb_ct_split_fifo: scoreboard bench for ct_split_fifo.
// Three instances cover drop, broadcast and narrow-counter modes.
module tb_ct_split_fifo;

    localparam int DEPTH = 2;

    logic        clk;
    logic        reset_n;
    logic [31:0] i_data;
    logic        i_valid;
    logic [1:0]  i_ready;

    logic        rdy_a, rdy_b, rdy_c;
    logic [63:0] dat_a, dat_b, dat_c;
    logic [1:0]  val_a, val_b, val_c;
    logic [15:0] drp_a, drp_b;
    logic [1:0]  drp_c;
    logic        unk_a, unk_b, unk_c;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [15:0] exp_drop;
    logic        exp_unk;

    ct_split_fifo #(.FLOWS(8'h10), .ENABLES(4'b1101), .DEPTH(DEPTH),
                    .DROP_UNKNOWN(1'b1), .CW(16)) u_a (
        .clk(clk), .reset_n(reset_n), .i_data(i_data), .i_valid(i_valid),
        .o_ready(rdy_a), .o_data(dat_a), .o_valid(val_a), .i_ready(i_ready),
        .o_drop_count(drp_a), .o_unknown(unk_a));

    ct_split_fifo #(.FLOWS(8'h10), .ENABLES(4'b1101), .DEPTH(DEPTH),
                    .DROP_UNKNOWN(1'b0), .CW(16)) u_b (
        .clk(clk), .reset_n(reset_n), .i_data(i_data), .i_valid(i_valid),
        .o_ready(rdy_b), .o_data(dat_b), .o_valid(val_b), .i_ready(i_ready),
        .o_drop_count(drp_b), .o_unknown(unk_b));

    ct_split_fifo #(.FLOWS(8'h10), .ENABLES(4'b1101), .DEPTH(DEPTH),
                    .DROP_UNKNOWN(1'b1), .CW(2)) u_c (
        .clk(clk), .reset_n(reset_n), .i_data(i_data), .i_valid(i_valid),
        .o_ready(rdy_c), .o_data(dat_c), .o_valid(val_c), .i_ready(i_ready),
        .o_drop_count(drp_c), .o_unknown(unk_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference flow table of instance A.
    function automatic void model(input logic [31:0] d,
                                  output logic [1:0] m, output logic hit);
        hit = 1'b1;
        if (d[3:0] == 4'd0)      m = 2'b01;
        else if (d[3:0] == 4'd1) m = 2'b11;
        else begin
            m   = 2'b00;
            hit = 1'b0;
        end
    endfunction

    // One cycle: drive at negedge, check, advance model, check stats.
    task automatic step(input logic v, input logic [31:0] d,
                        input logic [1:0] rdy, output logic acc);
        logic [1:0] m;
        logic       hit, er;
        i_valid = v;
        i_data  = d;
        i_ready = rdy;
        #1;
        model(d, m, hit);
        er = !((m[0] && q0.size() == DEPTH) || (m[1] && q1.size() == DEPTH));
        vectors++;
        if (rdy_a !== er) begin
            errors++;
            $display("FAIL o_ready: got %b want %b", rdy_a, er);
        end
        vectors++;
        if (val_a !== {q1.size() != 0, q0.size() != 0}) begin
            errors++;
            $display("FAIL o_valid: got %b want %b", val_a,
                     {q1.size() != 0, q0.size() != 0});
        end
        if (q0.size() != 0 && rdy[0]) begin
            vectors++;
            if (dat_a[31:0] !== q0[0]) begin
                errors++;
                $display("FAIL data0: got %h want %h", dat_a[31:0], q0[0]);
            end
            void'(q0.pop_front());
        end
        if (q1.size() != 0 && rdy[1]) begin
            vectors++;
            if (dat_a[63:32] !== q1[0]) begin
                errors++;
                $display("FAIL data1: got %h want %h", dat_a[63:32], q1[0]);
            end
            void'(q1.pop_front());
        end
        acc     = v && er;
        exp_unk = acc && !hit;
        if (acc) begin
            if (m[0]) q0.push_back(d);
            if (m[1]) q1.push_back(d);
            if (m == 2'b00 && exp_drop != 16'hffff) exp_drop++;
        end
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (unk_a !== exp_unk) begin
            errors++;
            $display("FAIL o_unknown: got %b want %b", unk_a, exp_unk);
        end
        vectors++;
        if (drp_a !== exp_drop) begin
            errors++;
            $display("FAIL drop_count: got %0d want %0d", drp_a, exp_drop);
        end
    endtask

    task automatic drain();
        logic acc;
        for (int n = 0; n < 8 && (q0.size() != 0 || q1.size() != 0); n++)
            step(1'b0, 32'h0, 2'b11, acc);
        vectors++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain: left %0d/%0d want 0/0", q0.size(), q1.size());
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        i_valid = 1'b0;
        i_data  = 32'h0;
        i_ready = 2'b00;
        q0.delete();
        q1.delete();
        exp_drop = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if (val_a !== 2'b00 || val_b !== 2'b00 || val_c !== 2'b00) begin
            errors++;
            $display("FAIL rst_valid: got %b/%b/%b want 0", val_a, val_b, val_c);
        end
        vectors++;
        if (drp_a !== 16'd0 || drp_c !== 2'd0 || unk_a !== 1'b0) begin
            errors++;
            $display("FAIL rst_drop: got %0d/%0d/%b want 0", drp_a, drp_c, unk_a);
        end
        vectors++;
        if (rdy_a !== 1'b1) begin
            errors++;
            $display("FAIL rst_ready: got %b want 1", rdy_a);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic acc;
        step(1'b1, 32'h0000_0A51, 2'b00, acc);
        vectors++;
        if (val_a !== 2'b11 || dat_a !== {2{32'h0000_0A51}}) begin
            errors++;
            $display("FAIL basic: got %b %h want 11 a51 x2", val_a, dat_a);
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic acc;
        step(1'b1, 32'h0000_1111, 2'b01, acc);
        step(1'b1, 32'h0000_2221, 2'b01, acc);
        step(1'b1, 32'h0000_3331, 2'b01, acc);
        vectors++;
        if (acc !== 1'b0) begin
            errors++;
            $display("FAIL bp_block: accepted %b want 0", acc);
        end
        step(1'b1, 32'h0000_3331, 2'b01, acc);
        step(1'b1, 32'h0000_3331, 2'b11, acc);
        vectors++;
        if (acc !== 1'b0) begin
            errors++;
            $display("FAIL bp_pop_same: accepted %b want 0", acc);
        end
        step(1'b1, 32'h0000_3331, 2'b11, acc);
        vectors++;
        if (acc !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: accepted %b want 1", acc);
        end
        drain();
    endtask

    task automatic test_unicast();
        logic acc;
        step(1'b1, 32'h0000_4441, 2'b00, acc);
        step(1'b1, 32'h0000_5551, 2'b00, acc);
        step(1'b0, 32'h0, 2'b01, acc);
        step(1'b0, 32'h0, 2'b01, acc);
        for (int n = 0; n < 4; n++) begin
            step(1'b1, 32'h0000_6000 + 32'(n << 4), 2'b01, acc);
            vectors++;
            if (acc !== 1'b1) begin
                errors++;
                $display("FAIL unicast%0d: accepted %b want 1", n, acc);
            end
        end
        drain();
    endtask

    task automatic test_unknown();
        logic acc;
        step(1'b1, 32'h0000_ABC7, 2'b00, acc);
        vectors++;
        if (acc !== 1'b1 || val_a !== 2'b00) begin
            errors++;
            $display("FAIL unk_drop: acc %b valid %b want 1 00", acc, val_a);
        end
        vectors++;
        if (val_b !== 2'b11 || dat_b !== {2{32'h0000_ABC7}} || unk_b !== 1'b1) begin
            errors++;
            $display("FAIL unk_bcast: got %b %h %b", val_b, dat_b, unk_b);
        end
        step(1'b0, 32'h0, 2'b11, acc);
        vectors++;
        if (val_b !== 2'b00 || drp_b !== 16'd0) begin
            errors++;
            $display("FAIL unk_bdrain: got %b %0d want 00 0", val_b, drp_b);
        end
    endtask

    task automatic test_saturation();
        logic acc;
        test_reset();
        for (int n = 1; n <= 5; n++) begin
            step(1'b1, 32'h0000_0F0F, 2'b11, acc);
            vectors++;
            if (drp_c !== 2'((n > 3) ? 3 : n)) begin
                errors++;
                $display("FAIL sat%0d: got %0d want %0d", n, drp_c, (n > 3) ? 3 : n);
            end
        end
        step(1'b0, 32'h0, 2'b11, acc);
        step(1'b0, 32'h0, 2'b11, acc);
    endtask

    task automatic test_midreset();
        logic acc;
        test_reset();
        step(1'b1, 32'h0000_7771, 2'b00, acc);
        step(1'b1, 32'h0000_8881, 2'b00, acc);
        i_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (val_a !== 2'b00) begin
            errors++;
            $display("FAIL midrst: got %b want 00", val_a);
        end
        #1;
        reset_n = 1'b1;
        q0.delete();
        q1.delete();
        exp_drop = '0;
        @(negedge clk);
        for (int n = 0; n < 3; n++) step(1'b0, 32'h0, 2'b11, acc);
        step(1'b1, 32'h0000_9991, 2'b00, acc);
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_unicast();
        test_unknown();
        test_saturation();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
